// File: rtl/jtcps1_pkg.sv
// Shared timing constants for the CPS1 video timing generator.
// The defaults describe the standard 512x262 CPS1 raster.
package jtcps1_pkg;

    localparam int CPS1_HW       = 9;
    localparam int CPS1_VW       = 9;
    localparam int CPS1_HTOTAL   = 512;
    localparam int CPS1_VTOTAL   = 262;
    localparam int CPS1_HB_START = 448;
    localparam int CPS1_HB_END   = 64;
    localparam int CPS1_HS_START = 460;
    localparam int CPS1_HS_END   = 496;
    localparam int CPS1_VB_START = 239;
    localparam int CPS1_VB_END   = 15;
    localparam int CPS1_VS_START = 256;
    localparam int CPS1_VS_END   = 1;

    localparam int OFFSET_W = 4;

endpackage

// File: rtl/jtcps1_timing_win.sv
// Wrap-aware window comparator: start inclusive, end exclusive.
// start > end wraps through zero, start == end is an empty window.
module jtcps1_timing_win #(
    parameter int W = 9
)(
    input  logic [W-1:0] value,
    input  logic [W-1:0] win_start,
    input  logic [W-1:0] win_end,
    output logic         in_win
);

    always_comb begin
        in_win = 1'b0;
        if (win_start < win_end) begin
            in_win = (value >= win_start) && (value < win_end);
        end else if (win_start > win_end) begin
            in_win = (value >= win_start) || (value < win_end);
        end
    end

endmodule

// File: rtl/jtcps1_timing_gen.sv
// CPS1 video timing generator: pixel/line counters, blanking, sync and frame
// counting, with per-frame programmable sync offsets.
module jtcps1_timing_gen
    import jtcps1_pkg::*;
#(
    parameter int HW       = CPS1_HW,
    parameter int VW       = CPS1_VW,
    parameter int HTOTAL   = CPS1_HTOTAL,
    parameter int VTOTAL   = CPS1_VTOTAL,
    parameter int HB_START = CPS1_HB_START,
    parameter int HB_END   = CPS1_HB_END,
    parameter int HS_START = CPS1_HS_START,
    parameter int HS_END   = CPS1_HS_END,
    parameter int VB_START = CPS1_VB_START,
    parameter int VB_END   = CPS1_VB_END,
    parameter int VS_START = CPS1_VS_START,
    parameter int VS_END   = CPS1_VS_END
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    input  logic [OFFSET_W-1:0] hoffset,
    input  logic [OFFSET_W-1:0] voffset,
    output logic [HW-1:0]       hdump,
    output logic [VW-1:0]       vdump,
    output logic [VW-1:0]       vrender,
    output logic [VW-1:0]       vrender1,
    output logic                start,
    output logic                HS,
    output logic                VS,
    output logic                HB,
    output logic                VB,
    output logic                preVB,
    output logic                frame,
    output logic [7:0]          frame_cnt
);

    localparam int MW = ((HW > VW) ? HW : VW) + 2;

    if (HTOTAL > 2**HW) begin : g_bad_htotal
        $fatal(1, "jtcps1_timing_gen: HTOTAL does not fit in HW bits");
    end
    if (VTOTAL > 2**VW) begin : g_bad_vtotal
        $fatal(1, "jtcps1_timing_gen: VTOTAL does not fit in VW bits");
    end
    if (HB_START >= HTOTAL || HB_END >= HTOTAL ||
        HS_START >= HTOTAL || HS_END >= HTOTAL) begin : g_bad_hwin
        $fatal(1, "jtcps1_timing_gen: horizontal window bound out of range");
    end
    if (VB_START >= VTOTAL || VB_END >= VTOTAL ||
        VS_START >= VTOTAL || VS_END >= VTOTAL) begin : g_bad_vwin
        $fatal(1, "jtcps1_timing_gen: vertical window bound out of range");
    end

    // Adds a small signed offset to a bound and folds the result into 0..total-1.
    function automatic logic [MW-1:0] mod_add(input logic [MW-1:0]       base,
                                              input logic [OFFSET_W-1:0] off,
                                              input logic [MW-1:0]       total);
        logic signed [MW-1:0] sum;
        sum = $signed(base) + $signed({{(MW-OFFSET_W){off[OFFSET_W-1]}}, off});
        if (sum < 0) begin
            sum = sum + $signed(total);
        end else if (sum >= $signed(total)) begin
            sum = sum - $signed(total);
        end
        return $unsigned(sum);
    endfunction

    logic [HW-1:0]       hdump_q, hdump_d;
    logic [VW-1:0]       vdump_q, vdump_d;
    logic [VW-1:0]       vrender_q, vrender_d;
    logic [VW-1:0]       vrender1_q, vrender1_d;
    logic                start_q, start_d;
    logic                hb_q, hb_d;
    logic                hs_q, hs_d;
    logic                vb_q, vb_d;
    logic                prevb_q, prevb_d;
    logic                vs_q, vs_d;
    logic                frame_q, frame_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [OFFSET_W-1:0] hoff_q, hoff_d;
    logic [OFFSET_W-1:0] voff_q, voff_d;

    logic                hwrap, vwrap;
    logic [VW-1:0]       vdump_nxt, vrender_nxt, vrender1_nxt;
    logic [OFFSET_W-1:0] voff_eff;
    logic [HW-1:0]       hs_start, hs_end;
    logic [VW-1:0]       vs_start, vs_end;
    logic                hb_win, hs_win, prevb_win, vs_win;

    assign hwrap = cen && (hdump_q == HW'(HTOTAL - 1));
    assign vwrap = hwrap && (vdump_q == VW'(VTOTAL - 1));

    assign vdump_nxt    = (vdump_q    == VW'(VTOTAL - 1)) ? '0 : vdump_q    + 1'b1;
    assign vrender_nxt  = (vrender_q  == VW'(VTOTAL - 1)) ? '0 : vrender_q  + 1'b1;
    assign vrender1_nxt = (vrender1_q == VW'(VTOTAL - 1)) ? '0 : vrender1_q + 1'b1;

    // VS for line 0 already uses the offset being sampled at the frame wrap.
    assign voff_eff = vwrap ? voffset : voff_q;

    assign hs_start = HW'(mod_add(MW'(HS_START), hoff_q,   MW'(HTOTAL)));
    assign hs_end   = HW'(mod_add(MW'(HS_END),   hoff_q,   MW'(HTOTAL)));
    assign vs_start = VW'(mod_add(MW'(VS_START), voff_eff, MW'(VTOTAL)));
    assign vs_end   = VW'(mod_add(MW'(VS_END),   voff_eff, MW'(VTOTAL)));

    jtcps1_timing_win #(.W(HW)) u_hb_win (
        .value     (hdump_q),
        .win_start (HW'(HB_START)),
        .win_end   (HW'(HB_END)),
        .in_win    (hb_win)
    );

    jtcps1_timing_win #(.W(HW)) u_hs_win (
        .value     (hdump_q),
        .win_start (hs_start),
        .win_end   (hs_end),
        .in_win    (hs_win)
    );

    jtcps1_timing_win #(.W(VW)) u_prevb_win (
        .value     (vdump_q),
        .win_start (VW'(VB_START)),
        .win_end   (VW'(VB_END)),
        .in_win    (prevb_win)
    );

    jtcps1_timing_win #(.W(VW)) u_vs_win (
        .value     (vdump_nxt),
        .win_start (vs_start),
        .win_end   (vs_end),
        .in_win    (vs_win)
    );

    always_comb begin
        hdump_d     = hdump_q;
        vdump_d     = vdump_q;
        vrender_d   = vrender_q;
        vrender1_d  = vrender1_q;
        start_d     = start_q;
        hb_d        = hb_q;
        hs_d        = hs_q;
        vb_d        = vb_q;
        prevb_d     = prevb_q;
        vs_d        = vs_q;
        frame_d     = frame_q;
        frame_cnt_d = frame_cnt_q;
        hoff_d      = hoff_q;
        voff_d      = voff_q;
        if (cen) begin
            hdump_d = hwrap ? '0 : hdump_q + 1'b1;
            start_d = hwrap;
            hb_d    = hb_win;
            hs_d    = hs_win;
            prevb_d = prevb_win;
            // Vertical state only moves at line boundaries.
            if (hwrap) begin
                vdump_d    = vdump_nxt;
                vrender_d  = vrender_nxt;
                vrender1_d = vrender1_nxt;
                vb_d       = prevb_q;
                vs_d       = vs_win;
                if (vwrap) begin
                    hoff_d      = hoffset;
                    voff_d      = voffset;
                    frame_d     = ~frame_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdump_q     <= '0;
            vdump_q     <= VW'(VTOTAL - 1);
            vrender_q   <= '0;
            vrender1_q  <= VW'(1);
            start_q     <= 1'b0;
            hb_q        <= 1'b1;
            hs_q        <= 1'b0;
            vb_q        <= 1'b1;
            prevb_q     <= 1'b1;
            vs_q        <= 1'b0;
            frame_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            hoff_q      <= '0;
            voff_q      <= '0;
        end else begin
            hdump_q     <= hdump_d;
            vdump_q     <= vdump_d;
            vrender_q   <= vrender_d;
            vrender1_q  <= vrender1_d;
            start_q     <= start_d;
            hb_q        <= hb_d;
            hs_q        <= hs_d;
            vb_q        <= vb_d;
            prevb_q     <= prevb_d;
            vs_q        <= vs_d;
            frame_q     <= frame_d;
            frame_cnt_q <= frame_cnt_d;
            hoff_q      <= hoff_d;
            voff_q      <= voff_d;
        end
    end

    assign hdump     = hdump_q;
    assign vdump     = vdump_q;
    assign vrender   = vrender_q;
    assign vrender1  = vrender1_q;
    assign start     = start_q;
    assign HS        = hs_q;
    assign VS        = vs_q;
    assign HB        = hb_q;
    assign VB        = vb_q;
    assign preVB     = prevb_q;
    assign frame     = frame_q;
    assign frame_cnt = frame_cnt_q;

endmodule
